// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD text buffer and its write arbiter.
// The ASCII filter helper is used only when LCD_ASCII_FILTER_EN is defined.
package lcd_pkg;

  localparam int LCD_CHARS  = 32;
  localparam int LCD_ADDR_W = 5;
  localparam int LCD_CHAR_W = 8;

  localparam logic [LCD_CHAR_W-1:0] LCD_SPACE   = 8'h20;
  localparam logic [LCD_CHAR_W-1:0] LCD_UNPRINT = 8'h3F;

  typedef enum logic {ST_IDLE, ST_CLEAR} lcd_state_e;

  typedef enum logic {REQ_A, REQ_B} req_id_e;

  // Map anything outside printable ASCII to '?'.
  function automatic logic [LCD_CHAR_W-1:0] lcd_ascii_filter(input logic [LCD_CHAR_W-1:0] c);
    return ((c < 8'h20) || (c > 8'h7E)) ? LCD_UNPRINT : c;
  endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way arbiter: round-robin on contention when FAIR=1, fixed A priority when FAIR=0.
// Purely combinational; the caller owns the last-grant register.
module lcd_rr_arb2
  import lcd_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic    valid_a_i,
  input  logic    valid_b_i,
  input  req_id_e last_grant_i,
  output logic    gnt_a_o,
  output logic    gnt_b_o
);

  always_comb begin
    gnt_a_o = valid_a_i && (!valid_b_i || !FAIR || (last_grant_i == REQ_B));
    gnt_b_o = valid_b_i && !gnt_a_o;
  end

endmodule

// File: rtl/lcd_text_arbiter.sv
// 32-character LCD text buffer with two arbitrated writers, a 32-cycle clear sequencer
// and a registered read port. Define LCD_ASCII_FILTER_EN to store unprintables as '?'.
module lcd_text_arbiter
  import lcd_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter bit         FAIR       = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_char,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_char,
  input  logic       clear_req,
  output logic       busy,
  input  logic [4:0] position,
  output logic [7:0] word
);

  lcd_state_e                  state_q, state_d;
  logic       [LCD_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  req_id_e                     last_grant_q, last_grant_d;
  logic       [LCD_CHAR_W-1:0] buf_q [LCD_CHARS];
  logic       [LCD_CHAR_W-1:0] word_q;

  logic                  arb_en;
  logic                  wr_en;
  logic [LCD_ADDR_W-1:0] wr_addr;
  logic [LCD_CHAR_W-1:0] wr_data;
  logic [LCD_CHAR_W-1:0] a_store, b_store;

`ifdef LCD_ASCII_FILTER_EN
  assign a_store = lcd_ascii_filter(a_char);
  assign b_store = lcd_ascii_filter(b_char);
`else
  assign a_store = a_char;
  assign b_store = b_char;
`endif

  // A clear request steals the cycle from both requesters.
  assign arb_en = (state_q == ST_IDLE) && !clear_req;

  lcd_rr_arb2 #(
    .FAIR (FAIR)
  ) u_arb (
    .valid_a_i    (a_valid && arb_en),
    .valid_b_i    (b_valid && arb_en),
    .last_grant_i (last_grant_q),
    .gnt_a_o      (a_ready),
    .gnt_b_o      (b_ready)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      last_grant_q <= REQ_B;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 5'd1;
        if (clr_cnt_q == LCD_ADDR_W'(LCD_CHARS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == ST_CLEAR);
    wr_en        = 1'b0;
    wr_addr      = clr_cnt_q;
    wr_data      = CLEAR_CHAR;
    last_grant_d = last_grant_q;
    if (busy) begin
      wr_en = 1'b1;
    end else if (a_valid && a_ready) begin
      wr_en        = 1'b1;
      wr_addr      = a_addr;
      wr_data      = a_store;
      last_grant_d = REQ_A;
    end else if (b_valid && b_ready) begin
      wr_en        = 1'b1;
      wr_addr      = b_addr;
      wr_data      = b_store;
      last_grant_d = REQ_B;
    end
  end

  // Read samples the pre-write contents, so a same-edge write shows up one cycle later.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < LCD_CHARS; i++) buf_q[i] <= CLEAR_CHAR;
      word_q <= CLEAR_CHAR;
    end else begin
      if (wr_en) buf_q[wr_addr] <= wr_data;
      word_q <= buf_q[position];
    end
  end

  assign word = word_q;

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Directed self-checking bench for lcd_text_arbiter; a FAIR=0 instance checks fixed priority.
module tb_lcd_text_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, clear_req;
  logic [4:0] a_addr, b_addr, position;
  logic [7:0] a_char, b_char;
  logic       a_ready, b_ready, busy;
  logic [7:0] word;

  logic       fx_a_valid, fx_b_valid;
  logic [4:0] fx_a_addr, fx_b_addr;
  logic [7:0] fx_a_char, fx_b_char;
  logic       fx_a_ready, fx_b_ready, fx_busy;
  logic [7:0] fx_word;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  lcd_text_arbiter #(.CLEAR_CHAR(8'h20), .FAIR(1'b1)) dut (
    .CLOCK_50 (clk),       .RESET    (rst),
    .a_valid  (a_valid),   .a_ready  (a_ready), .a_addr (a_addr), .a_char (a_char),
    .b_valid  (b_valid),   .b_ready  (b_ready), .b_addr (b_addr), .b_char (b_char),
    .clear_req(clear_req), .busy     (busy),
    .position (position),  .word     (word)
  );

  lcd_text_arbiter #(.CLEAR_CHAR(8'h20), .FAIR(1'b0)) dut_fx (
    .CLOCK_50 (clk),        .RESET   (rst),
    .a_valid  (fx_a_valid), .a_ready (fx_a_ready), .a_addr (fx_a_addr), .a_char (fx_a_char),
    .b_valid  (fx_b_valid), .b_ready (fx_b_ready), .b_addr (fx_b_addr), .b_char (fx_b_char),
    .clear_req(clear_req),  .busy    (fx_busy),
    .position (position),   .word    (fx_word)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_55();
    for (int i = 0; i < 32; i++) begin
      a_valid = 1'b1; a_addr = 5'(i); a_char = 8'h55;
      tick();
    end
    a_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (busy !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%b a_ready=%b b_ready=%b, required 0 0 0", busy, a_ready,
               b_ready);
    end
    total++;
    if (word !== 8'h20) begin
      bad++;
      $display("FAIL reset_word: got %h, required 20", word);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      position = 5'(i);
      tick();
      total++;
      if (word !== 8'h20) begin
        bad++;
        $display("FAIL reset_sweep[%0d]: got %h, required 20", i, word);
      end
    end
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_addr = 5'd3; a_char = 8'h41; position = 5'd3;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_a_ready: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
    end
    tick();
    a_valid = 1'b0;
    total++;
    if (word !== 8'h20) begin
      bad++;
      $display("FAIL read_before_write: got %h, required 20", word);
    end
    tick();
    total++;
    if (word !== 8'h41) begin
      bad++;
      $display("FAIL single_a_word: got %h, required 41", word);
    end
  endtask

  task automatic test_contention();
    int ai = 0, bi = 0, fai = 0, fbi = 0;
    logic [1:0] exp_fair [4];
    logic [1:0] exp_fix  [4];
    exp_fair = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_fix  = '{2'b10, 2'b10, 2'b01, 2'b01};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      a_valid = (ai < 2);  a_addr = 5'd0; a_char = (ai == 0) ? 8'h61 : 8'h62;
      b_valid = (bi < 2);  b_addr = 5'd1; b_char = (bi == 0) ? 8'h78 : 8'h79;
      fx_a_valid = (fai < 2); fx_a_addr = 5'd0; fx_a_char = (fai == 0) ? 8'h61 : 8'h62;
      fx_b_valid = (fbi < 2); fx_b_addr = 5'd1; fx_b_char = (fbi == 0) ? 8'h78 : 8'h79;
      #1;
      total++;
      if ({a_ready, b_ready} !== exp_fair[c]) begin
        bad++;
        $display("FAIL fair_grant[%0d]: got %b, required %b", c, {a_ready, b_ready}, exp_fair[c]);
      end
      total++;
      if ({fx_a_ready, fx_b_ready} !== exp_fix[c]) begin
        bad++;
        $display("FAIL fixed_grant[%0d]: got %b, required %b", c, {fx_a_ready, fx_b_ready},
                 exp_fix[c]);
      end
      if (a_valid && a_ready) ai++;
      if (b_valid && b_ready) bi++;
      if (fx_a_valid && fx_a_ready) fai++;
      if (fx_b_valid && fx_b_ready) fbi++;
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0; fx_a_valid = 1'b0; fx_b_valid = 1'b0;
    position = 5'd0;
    tick();
    total++;
    if (word !== 8'h62 || fx_word !== 8'h62) begin
      bad++;
      $display("FAIL contention_buf0: fair=%h fixed=%h, required 62 62", word, fx_word);
    end
    position = 5'd1;
    tick();
    total++;
    if (word !== 8'h79 || fx_word !== 8'h79) begin
      bad++;
      $display("FAIL contention_buf1: fair=%h fixed=%h, required 79 79", word, fx_word);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    fill_55();
    clear_req = 1'b1; a_valid = 1'b1; a_addr = 5'd5; a_char = 8'h51;
    #1;
    total++;
    if (a_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_priority: a_ready=%b, required 0", a_ready);
    end
    tick();
    clear_req = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      total++;
      if (a_ready !== 1'b0) begin
        bad++;
        $display("FAIL clear_ready[%0d]: a_ready=%b, required 0", n, a_ready);
      end
      n++;
      tick();
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL clear_busy_len: got %0d cycles, required 32", n);
    end
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear_first_idle: a_ready=%b, required 1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      position = 5'(i);
      tick();
      total++;
      if (word !== ((i == 5) ? 8'h51 : 8'h20)) begin
        bad++;
        $display("FAIL clear_sweep[%0d]: got %h, required %h", i, word,
                 (i == 5) ? 8'h51 : 8'h20);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    fill_55();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || word !== 8'h20) begin
      bad++;
      $display("FAIL mid_clear_reset: busy=%b word=%h, required 0 20", busy, word);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      position = 5'(i);
      tick();
      total++;
      if (word !== 8'h20) begin
        bad++;
        $display("FAIL mid_clear_sweep[%0d]: got %h, required 20", i, word);
      end
    end
    b_valid = 1'b1; b_addr = 5'd9; b_char = 8'h42; position = 5'd9;
    #1;
    total++;
    if (b_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_b_ready: got %b, required 1", b_ready);
    end
    tick();
    b_valid = 1'b0;
    tick();
    total++;
    if (word !== 8'h42) begin
      bad++;
      $display("FAIL post_reset_b_word: got %h, required 42", word);
    end
  endtask

  task automatic test_filter();
    logic [7:0] chars [3];
    logic [7:0] exp   [3];
    chars = '{8'h0A, 8'h7F, 8'h7E};
`ifdef LCD_ASCII_FILTER_EN
    exp = '{8'h3F, 8'h3F, 8'h7E};
`else
    exp = '{8'h0A, 8'h7F, 8'h7E};
`endif
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_addr = 5'(i + 2); a_char = chars[i];
      tick();
    end
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      position = 5'(i + 2);
      tick();
      total++;
      if (word !== exp[i]) begin
        bad++;
        $display("FAIL filter[%h]: got %h, required %h", chars[i], word, exp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; position = '0;
    a_valid = 1'b0; a_addr = '0; a_char = '0;
    b_valid = 1'b0; b_addr = '0; b_char = '0;
    fx_a_valid = 1'b0; fx_a_addr = '0; fx_a_char = '0;
    fx_b_valid = 1'b0; fx_b_addr = '0; fx_b_char = '0;
    test_reset();
    test_single_a();
    test_contention();
    test_clear();
    test_reset_mid_clear();
    test_filter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_text_arbiter.md
Name: lcd_text_arbiter

Overview:
- 32-character text buffer that feeds LCD_Display: LCD_Display drives position, and this block returns word.
- Shares buffer write access between two requesters: A = processor store path, B = debug/status writer.
- Valid/ready handshake with round-robin arbitration.
- Includes a 32-cycle clear sequencer.
- Sits between the processor datapath and the lcd top level, replacing any hard-wired character source.

Parameters:
CLEAR_CHAR, 8'h20, character written by reset and by the clear sequence.
FAIR, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins.

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RESET  in  1  asynchronous, active-high reset
a_valid  in  1  requester A write request
a_ready  out  1  requester A grant; the write happens on an edge where a_valid && a_ready
a_addr  in  5  requester A character index, 0-31 (0-15 line 1, 16-31 line 2)
a_char  in  8  requester A character code
b_valid  in  1  requester B write request
b_ready  out  1  requester B grant
b_addr  in  5  requester B character index
b_char  in  8  requester B character code
clear_req  in  1  single-cycle request to fill the buffer with CLEAR_CHAR
busy  out  1  high while the clear sequence runs
position  in  5  read index from LCD_Display
word  out  8  registered character at position

Behaviour:
- Storage: 32 x 8 register array.
- Reset (async, RESET=1):
  - All entries = CLEAR_CHAR; word = CLEAR_CHAR.
  - busy=0, a_ready=0, b_ready=0.
  - State = IDLE, clr_cnt=0, last_grant=B, so A wins the first contention.
- Read path: word <= buf[position] every cycle, giving 1-cycle latency. Read-before-write:
  - A write to the entry at the current position is visible on word one cycle after the write edge.
  - The same edge still returns the old value.
- State IDLE:
  - clear_req=1: a_ready=b_ready=0 this cycle; next state CLEAR, clr_cnt=0, busy=1 next cycle. clear_req has priority over both requesters.
  - Otherwise, arbitration (combinational readys from registered state):
    - Only a_valid: a_ready=1.
    - Only b_valid: b_ready=1.
    - Both valid with FAIR=1: grant the requester not equal to last_grant.
    - Both valid with FAIR=0: grant A.
    - At most one ready is high per cycle; ready never asserts without its valid.
  - On a handshake edge: buf[addr] <= char and last_grant <= winner. last_grant updates on every grant, not only on contention.
  - Requester rule: valid, addr and char are held stable until ready. The block does not depend on this, since the write samples the current inputs.
- State CLEAR:
  - Each cycle: buf[clr_cnt] <= CLEAR_CHAR, clr_cnt++.
  - a_ready=b_ready=0; clear_req is ignored (no queuing).
  - When clr_cnt==31, that edge writes entry 31 and returns to IDLE with busy=0.
  - Total busy time is exactly 32 cycles.
  - Requests pending during CLEAR are served from the first IDLE cycle.
- Address arithmetic: 5-bit, no wrap logic needed. clr_cnt is 5 bits, and a full range 31->0 wraps exactly at exit.
- Reset mid-CLEAR: aborts immediately; the buffer is all CLEAR_CHAR regardless of progress.
- Same address from A and B: impossible in one cycle, because only one grant per cycle exists.

Optional Feature:
Macro LCD_ASCII_FILTER_EN.
- Defined: on any requester write, a char < 8'h20 or > 8'h7E is stored as 8'h3F ('?'). CLEAR_CHAR is stored unfiltered.
- Undefined: chars are stored verbatim.

Decomposition:
- Package lcd_pkg:
  - Constants LCD_CHARS=32, LCD_ADDR_W=5, LCD_CHAR_W=8, LCD_SPACE=8'h20, LCD_UNPRINT=8'h3F.
  - State enum {ST_IDLE, ST_CLEAR}.
  - Requester id enum {REQ_A, REQ_B}.
- One natural sub-module: lcd_rr_arb2. It is the 2-way round-robin arbiter (valids, FAIR, last_grant in; grants out) and is reusable for other shared peripherals.
- Buffer and clear FSM stay in the top.

Test Plan:
- Reset release, position swept 0..31 -> word = 8'h20 for every index, each one cycle after position applied.
- A writes addr 3 = 8'h41 alone -> a_ready=1 the same cycle; position=3 gives word=8'h41 on the following cycle.
- A and B both valid for 4 cycles (A addr 0 chars 'a','b'; B addr 1 chars 'x','y'), FAIR=1 -> grants A,B,A,B; final buf[0]='b', buf[1]='y'.
  - Same stimulus with FAIR=0 -> A granted twice first, then B twice.
- Fill all entries with 8'h55, pulse clear_req with a_valid held -> busy high exactly 32 cycles, a_ready=0 throughout; all entries 8'h20 after; A's write lands on the first IDLE cycle.
- Assert RESET at clear cycle 10 while buf holds 8'h55 -> all entries 8'h20 immediately, busy=0; a subsequent B write succeeds.
- With LCD_ASCII_FILTER_EN: write 8'h0A and 8'h7F -> stored 8'h3F; 8'h7E stored unchanged. Without the macro -> 8'h0A stored.
